// File: rtl/offnariscv_pkg.sv
// Shared ACE snoop definitions: channel widths, snoop encodings,
// CR response layout and responder FSM states.
package offnariscv_pkg;

    localparam int ACE_ACADDR_WIDTH     = 32;
    localparam int ACE_ACSNOOP_WIDTH    = 4;
    localparam int ACE_ACPROT_WIDTH     = 3;
    localparam int ACE_CRRESP_WIDTH     = 5;
    localparam int ACE_CDDATA_WIDTH     = 32;
    localparam int ACE_CACHE_LINE_BEATS = 4;

    typedef enum logic [3:0] {
        READ_ONCE             = 4'b0000,
        READ_SHARED           = 4'b0001,
        READ_CLEAN            = 4'b0010,
        READ_NOT_SHARED_DIRTY = 4'b0011,
        READ_UNIQUE           = 4'b0111,
        CLEAN_SHARED          = 4'b1000,
        CLEAN_INVALID         = 4'b1001,
        MAKE_INVALID          = 4'b1101
    } ace_acsnoop_e;

    typedef struct packed {
        logic was_unique;
        logic is_shared;
        logic pass_dirty;
        logic error;
        logic data_transfer;
    } ace_crresp_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_RESP,
        S_DATA_RD,
        S_DATA_OUT,
        S_UPDATE
    } ace_snp_state_e;

endpackage

// File: rtl/ace_snoop_decode.sv
// Snoop response table: maps snoop type and line state to CR response,
// data-transfer need and the cache state-update actions.
// Ports: acsnoop, hit/dirty/uniq in; crresp, need_data, upd_* out.
module ace_snoop_decode
    import offnariscv_pkg::*;
(
    input  logic [ACE_ACSNOOP_WIDTH-1:0] acsnoop,
    input  logic                         hit,
    input  logic                         dirty,
    input  logic                         uniq,
    output ace_crresp_t                  crresp,
    output logic                         need_data,
    output logic                         upd_inv,
    output logic                         upd_clr_dirty,
    output logic                         upd_clr_unique
);

    always_comb begin
        crresp         = '0;
        upd_inv        = 1'b0;
        upd_clr_dirty  = 1'b0;
        upd_clr_unique = 1'b0;
        if (hit) begin
            unique case (acsnoop)
                READ_ONCE: begin
                    crresp.data_transfer = 1'b1;
                    crresp.is_shared     = 1'b1;
                    crresp.was_unique    = uniq;
                end
                READ_SHARED, READ_CLEAN, READ_NOT_SHARED_DIRTY: begin
                    crresp.data_transfer = 1'b1;
                    crresp.is_shared     = 1'b1;
                    crresp.pass_dirty    = dirty;
                    crresp.was_unique    = uniq;
                    upd_clr_unique       = 1'b1;
                    upd_clr_dirty        = dirty;
                end
                READ_UNIQUE: begin
                    crresp.data_transfer = 1'b1;
                    crresp.pass_dirty    = dirty;
                    crresp.was_unique    = uniq;
                    upd_inv              = 1'b1;
                end
                CLEAN_SHARED: begin
                    crresp.data_transfer = dirty;
                    crresp.is_shared     = 1'b1;
                    crresp.pass_dirty    = dirty;
                    crresp.was_unique    = uniq;
                    upd_clr_dirty        = dirty;
                end
                CLEAN_INVALID: begin
                    crresp.data_transfer = dirty;
                    crresp.pass_dirty    = dirty;
                    crresp.was_unique    = uniq;
                    upd_inv              = 1'b1;
                end
                MAKE_INVALID: begin
                    crresp.was_unique    = uniq;
                    upd_inv              = 1'b1;
                end
                default: ;
            endcase
        end
        need_data = crresp.data_transfer;
    end

endmodule

// File: rtl/ace_snoop_responder.sv
// ACE snoop responder for one L1 D-cache: AC accept, cache lookup,
// CR response, wrapped CD line stream, then coherence-state update.
// Ports: AC/CR/CD snoop channels, lk_* lookup, rd_* beat read,
// upd_* state update handshake.
module ace_snoop_responder
    import offnariscv_pkg::*;
#(
    parameter  int LINE_BEATS = ACE_CACHE_LINE_BEATS,
    localparam int BEAT_IDX_W = $clog2(LINE_BEATS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         acvalid,
    output logic                         acready,
    input  logic [ACE_ACADDR_WIDTH-1:0]  acaddr,
    input  logic [ACE_ACSNOOP_WIDTH-1:0] acsnoop,
    input  logic [ACE_ACPROT_WIDTH-1:0]  acprot,
    output logic                         crvalid,
    input  logic                         crready,
    output logic [ACE_CRRESP_WIDTH-1:0]  crresp,
    output logic                         cdvalid,
    input  logic                         cdready,
    output logic [ACE_CDDATA_WIDTH-1:0]  cddata,
    output logic                         cdlast,
    output logic                         lk_req,
    output logic [ACE_ACADDR_WIDTH-1:0]  lk_addr,
    input  logic                         lk_ack,
    input  logic                         lk_hit,
    input  logic                         lk_dirty,
    input  logic                         lk_unique,
    output logic                         rd_req,
    output logic [BEAT_IDX_W-1:0]        rd_beat,
    input  logic [ACE_CDDATA_WIDTH-1:0]  rd_data,
    output logic                         upd_valid,
    input  logic                         upd_ready,
    output logic                         upd_inv,
    output logic                         upd_clr_dirty,
    output logic                         upd_clr_unique
);

    localparam int BEAT_LSB = $clog2(ACE_CDDATA_WIDTH / 8);

    ace_snp_state_e                  state_q, state_d;
    logic                            acready_q, acready_d;
    logic [ACE_ACADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [ACE_ACSNOOP_WIDTH-1:0]    snoop_q, snoop_d;
    ace_crresp_t                     crresp_q, crresp_d;
    logic                            need_data_q, need_data_d;
    logic                            inv_q, inv_d;
    logic                            clr_dirty_q, clr_dirty_d;
    logic                            clr_unique_q, clr_unique_d;
    logic [BEAT_IDX_W-1:0]           beat_q, beat_d;
    logic [BEAT_IDX_W-1:0]           cnt_q, cnt_d;
    logic                            phase_q, phase_d;
    logic [ACE_CDDATA_WIDTH-1:0]     cddata_q, cddata_d;

    ace_crresp_t dec_crresp;
    logic        dec_need_data;
    logic        dec_inv;
    logic        dec_clr_dirty;
    logic        dec_clr_unique;
    logic        any_upd;
    logic        last_beat;
    logic        unused_acprot;

    assign unused_acprot = ^acprot;

    ace_snoop_decode u_decode (
        .acsnoop        (snoop_q),
        .hit            (lk_hit),
        .dirty          (lk_dirty),
        .uniq           (lk_unique),
        .crresp         (dec_crresp),
        .need_data      (dec_need_data),
        .upd_inv        (dec_inv),
        .upd_clr_dirty  (dec_clr_dirty),
        .upd_clr_unique (dec_clr_unique)
    );

    assign any_upd   = inv_q | clr_dirty_q | clr_unique_q;
    assign last_beat = (cnt_q == BEAT_IDX_W'(LINE_BEATS - 1));

    assign acready        = acready_q;
    assign crresp         = crresp_q;
    assign cddata         = cddata_q;
    assign lk_addr        = addr_q;
    assign rd_beat        = beat_q;
    assign upd_inv        = inv_q;
    assign upd_clr_dirty  = clr_dirty_q;
    assign upd_clr_unique = clr_unique_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        snoop_d      = snoop_q;
        crresp_d     = crresp_q;
        need_data_d  = need_data_q;
        inv_d        = inv_q;
        clr_dirty_d  = clr_dirty_q;
        clr_unique_d = clr_unique_q;
        beat_d       = beat_q;
        cnt_d        = cnt_q;
        phase_d      = phase_q;
        cddata_d     = cddata_q;
        crvalid      = 1'b0;
        cdvalid      = 1'b0;
        cdlast       = 1'b0;
        lk_req       = 1'b0;
        rd_req       = 1'b0;
        upd_valid    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (acvalid && acready_q) begin
                    addr_d  = acaddr;
                    snoop_d = acsnoop;
                    // Critical beat first: the line streams from the
                    // beat holding the snooped address and wraps.
                    beat_d  = acaddr[BEAT_LSB +: BEAT_IDX_W];
                    cnt_d   = '0;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                lk_req = 1'b1;
                if (lk_ack) begin
                    crresp_d     = dec_crresp;
                    need_data_d  = dec_need_data;
                    inv_d        = dec_inv;
                    clr_dirty_d  = dec_clr_dirty;
                    clr_unique_d = dec_clr_unique;
                    state_d      = S_RESP;
                end
            end
            S_RESP: begin
                crvalid = 1'b1;
                if (crready) begin
                    if (need_data_q)  state_d = S_DATA_RD;
                    else if (any_upd) state_d = S_UPDATE;
                    else              state_d = S_IDLE;
                end
            end
            S_DATA_RD: begin
                rd_req  = 1'b1;
                phase_d = 1'b0;
                state_d = S_DATA_OUT;
            end
            S_DATA_OUT: begin
                // First cycle captures the read beat; it is presented
                // from the next cycle so cddata is a clean flop.
                if (!phase_q) begin
                    cddata_d = rd_data;
                    phase_d  = 1'b1;
                end else begin
                    cdvalid = 1'b1;
                    cdlast  = last_beat;
                    if (cdready) begin
                        phase_d = 1'b0;
                        if (last_beat) begin
                            state_d = any_upd ? S_UPDATE : S_IDLE;
                        end else begin
                            cnt_d   = cnt_q + BEAT_IDX_W'(1);
                            beat_d  = beat_q + BEAT_IDX_W'(1);
                            state_d = S_DATA_RD;
                        end
                    end
                end
            end
            S_UPDATE: begin
                upd_valid = 1'b1;
                if (upd_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Registered so acready is low while reset is held.
        acready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            acready_q    <= 1'b0;
            addr_q       <= '0;
            snoop_q      <= '0;
            crresp_q     <= '0;
            need_data_q  <= 1'b0;
            inv_q        <= 1'b0;
            clr_dirty_q  <= 1'b0;
            clr_unique_q <= 1'b0;
            beat_q       <= '0;
            cnt_q        <= '0;
            phase_q      <= 1'b0;
            cddata_q     <= '0;
        end else begin
            state_q      <= state_d;
            acready_q    <= acready_d;
            addr_q       <= addr_d;
            snoop_q      <= snoop_d;
            crresp_q     <= crresp_d;
            need_data_q  <= need_data_d;
            inv_q        <= inv_d;
            clr_dirty_q  <= clr_dirty_d;
            clr_unique_q <= clr_unique_d;
            beat_q       <= beat_d;
            cnt_q        <= cnt_d;
            phase_q      <= phase_d;
            cddata_q     <= cddata_d;
        end
    end

endmodule

// File: tb/tb_ace_snoop_responder.sv
// Self-checking bench for ace_snoop_responder: directed test-plan
// snoops plus randomized snoops checked against a rule-level model.
module tb_ace_snoop_responder;
    import offnariscv_pkg::*;

    localparam int LB   = ACE_CACHE_LINE_BEATS;
    localparam int BW   = $clog2(LB);
    localparam int BLSB = $clog2(ACE_CDDATA_WIDTH / 8);

    logic                         clk = 1'b0;
    logic                         rst_n = 1'b0;
    logic                         acvalid = 1'b0;
    logic                         acready;
    logic [ACE_ACADDR_WIDTH-1:0]  acaddr = '0;
    logic [ACE_ACSNOOP_WIDTH-1:0] acsnoop = '0;
    logic [ACE_ACPROT_WIDTH-1:0]  acprot = '0;
    logic                         crvalid;
    logic                         crready = 1'b0;
    logic [ACE_CRRESP_WIDTH-1:0]  crresp;
    logic                         cdvalid;
    logic                         cdready = 1'b0;
    logic [ACE_CDDATA_WIDTH-1:0]  cddata;
    logic                         cdlast;
    logic                         lk_req;
    logic [ACE_ACADDR_WIDTH-1:0]  lk_addr;
    logic                         lk_ack = 1'b0;
    logic                         lk_hit = 1'b0;
    logic                         lk_dirty = 1'b0;
    logic                         lk_unique = 1'b0;
    logic                         rd_req;
    logic [BW-1:0]                rd_beat;
    logic [ACE_CDDATA_WIDTH-1:0]  rd_data = '0;
    logic                         upd_valid;
    logic                         upd_ready = 1'b0;
    logic                         upd_inv;
    logic                         upd_clr_dirty;
    logic                         upd_clr_unique;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ace_snoop_responder #(.LINE_BEATS(LB)) dut (
        .clk(clk), .rst_n(rst_n),
        .acvalid(acvalid), .acready(acready), .acaddr(acaddr),
        .acsnoop(acsnoop), .acprot(acprot),
        .crvalid(crvalid), .crready(crready), .crresp(crresp),
        .cdvalid(cdvalid), .cdready(cdready), .cddata(cddata),
        .cdlast(cdlast),
        .lk_req(lk_req), .lk_addr(lk_addr), .lk_ack(lk_ack),
        .lk_hit(lk_hit), .lk_dirty(lk_dirty), .lk_unique(lk_unique),
        .rd_req(rd_req), .rd_beat(rd_beat), .rd_data(rd_data),
        .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_inv(upd_inv), .upd_clr_dirty(upd_clr_dirty),
        .upd_clr_unique(upd_clr_unique)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Rule-level model of the snoop response table.
    function automatic void model(input logic [3:0] s, input logic h,
                                  input logic d, input logic u,
                                  output logic [4:0] cr,
                                  output logic inv, output logic cdirty,
                                  output logic cuniq);
        logic rd, cln, mk, is;
        rd  = s inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd7};
        cln = s inside {4'd8, 4'd9};
        mk  = (s == 4'd13);
        cr = '0; inv = 1'b0; cdirty = 1'b0; cuniq = 1'b0;
        if (h && (rd || cln || mk)) begin
            is     = s inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd8};
            cr     = {u, is, d && (s != 4'd0) && !mk, 1'b0,
                      rd || (cln && d)};
            inv    = s inside {4'd7, 4'd9, 4'd13};
            cuniq  = s inside {4'd1, 4'd2, 4'd3};
            cdirty = d && (s inside {4'd1, 4'd2, 4'd3, 4'd8});
        end
    endfunction

    function automatic logic [31:0] data_of(input logic [31:0] a,
                                            input int b);
        return (a & ~32'h3F) ^ (32'(b) * 32'h01010101) ^ 32'h5A00_0000;
    endfunction

    task automatic run_snoop(input logic [3:0] s, input logic [31:0] a,
                             input logic h, input logic d, input logic u,
                             input int cr_stall, input int upd_stall,
                             input int abort_beat);
        logic [4:0] ecr;
        logic einv, ecd, ecu, eupd;
        int eb, bk, n;
        bit done;
        model(s, h, d, u, ecr, einv, ecd, ecu);
        eupd = einv | ecd | ecu;
        eb = int'((a >> BLSB) % LB);

        chk("acready_idle", acready, 1);
        acvalid = 1'b1; acaddr = a; acsnoop = s;
        acprot = ACE_ACPROT_WIDTH'($urandom);
        @(negedge clk);
        acvalid = 1'b0; acaddr = $urandom; acsnoop = 4'($urandom);
        chk("acready_busy", acready, 0);
        repeat ($urandom_range(0, 3)) begin
            chk("lk_req_hold", lk_req, 1);
            @(negedge clk);
        end
        chk("lk_req", lk_req, 1);
        chk("lk_addr", lk_addr, a);
        lk_ack = 1'b1; lk_hit = h; lk_dirty = d; lk_unique = u;
        @(negedge clk);
        lk_ack = 1'b0;
        lk_hit = 1'($urandom); lk_dirty = 1'($urandom);
        lk_unique = 1'($urandom);
        chk("lk_req_drop", lk_req, 0);

        for (int i = 0; i <= cr_stall; i++) begin
            chk("crvalid", crvalid, 1);
            chk("crresp", crresp, ecr);
            chk("cd_before_cr", cdvalid, 0);
            chk("acready_cr", acready, 0);
            if (i == cr_stall) crready = 1'b1;
            @(negedge clk);
        end
        crready = 1'b0;
        chk("crvalid_drop", crvalid, 0);

        if (ecr[0]) begin
            for (int k = 0; k < LB; k++) begin
                bk = (eb + k) % LB;
                chk("rd_req", rd_req, 1);
                chk("rd_beat", rd_beat, bk);
                rd_data = data_of(a, bk);
                @(negedge clk);
                chk("rd_req_pulse", rd_req, 0);
                chk("cdvalid_capture", cdvalid, 0);
                @(negedge clk);
                rd_data = $urandom;
                done = 1'b0; n = 0;
                while (!done) begin
                    chk("cdvalid", cdvalid, 1);
                    chk("cddata", cddata, data_of(a, bk));
                    chk("cdlast", cdlast, (k == LB - 1));
                    chk("upd_before_cd", upd_valid, 0);
                    if (k == abort_beat) begin
                        rst_n = 1'b0;
                        @(negedge clk);
                        chk("rst_crvalid", crvalid, 0);
                        chk("rst_cdvalid", cdvalid, 0);
                        chk("rst_cdlast", cdlast, 0);
                        chk("rst_lk_req", lk_req, 0);
                        chk("rst_rd_req", rd_req, 0);
                        chk("rst_upd_valid", upd_valid, 0);
                        chk("rst_acready", acready, 0);
                        rst_n = 1'b1;
                        @(negedge clk);
                        chk("post_rst_acready", acready, 1);
                        repeat (3) begin
                            chk("post_rst_no_upd", upd_valid, 0);
                            chk("post_rst_no_cd", cdvalid, 0);
                            @(negedge clk);
                        end
                        return;
                    end
                    cdready = (n >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
                    @(negedge clk);
                    n++;
                    if (cdready) done = 1'b1;
                    cdready = 1'b0;
                end
            end
        end else begin
            chk("no_rd_req", rd_req, 0);
            chk("no_cdvalid", cdvalid, 0);
        end

        if (eupd) begin
            for (int i = 0; i <= upd_stall; i++) begin
                chk("upd_valid", upd_valid, 1);
                chk("upd_inv", upd_inv, einv);
                chk("upd_clr_dirty", upd_clr_dirty, ecd);
                chk("upd_clr_unique", upd_clr_unique, ecu);
                chk("acready_upd", acready, 0);
                chk("cd_during_upd", cdvalid, 0);
                if (i == upd_stall) upd_ready = 1'b1;
                @(negedge clk);
            end
            upd_ready = 1'b0;
        end
        chk("upd_valid_idle", upd_valid, 0);
        chk("acready_done", acready, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_acready", acready, 0);
        chk("rst_crvalid", crvalid, 0);
        chk("rst_cdvalid", cdvalid, 0);
        chk("rst_cdlast", cdlast, 0);
        chk("rst_lk_req", lk_req, 0);
        chk("rst_rd_req", rd_req, 0);
        chk("rst_upd_valid", upd_valid, 0);
        chk("rst_crresp", crresp, 0);
        chk("rst_cddata", cddata, 0);
        chk("rst_rd_beat", rd_beat, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_snoop(4'b0001, 32'h1008, 1, 1, 1, 0, 0, -1);
        run_snoop(4'b0111, 32'h2000, 1, 0, 1, 0, 0, -1);
        run_snoop(4'b1001, 32'h3000, 1, 0, 1, 0, 0, -1);
        run_snoop(4'b1001, 32'h3004, 1, 1, 1, 1, 1, -1);
        run_snoop(4'b0001, 32'h4000, 0, 1, 1, 0, 0, -1);
        run_snoop(4'b1111, 32'h4100, 1, 1, 1, 0, 0, -1);
        run_snoop(4'b0000, 32'h500C, 1, 1, 0, 2, 0, -1);
        run_snoop(4'b1101, 32'h6008, 1, 1, 1, 0, 2, -1);
        run_snoop(4'b0001, 32'h700C, 1, 1, 0, 5, 3, -1);
        run_snoop(4'b0001, 32'h1008, 1, 1, 1, 0, 0, 2);

        for (int r = 0; r < 30; r++) begin
            run_snoop(4'($urandom_range(0, 15)), $urandom,
                      1'($urandom_range(0, 3) != 0), 1'($urandom),
                      1'($urandom), $urandom_range(0, 4),
                      $urandom_range(0, 4), -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ace_snoop_responder.md
Name: ace_snoop_responder

Overview:
Responder end of the ACE snoop channels (AC/CR/CD) for a single L1 data cache. It accepts one snoop from the interconnect, looks up the line through a cache-side lookup port, and returns the CR response. When data is required it streams the line on CD, then issues the required coherence-state update to the cache. Only one snoop is in flight at a time.

Parameters:
LINE_BEATS, 4, CD beats per cache line (power of 2, ≥2); line bytes = LINE_BEATS*ACE_CDDATA_WIDTH/8
BEAT_IDX_W, $clog2(LINE_BEATS), beat index width (derived, not overridable)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
acvalid  in  1  snoop address valid
acready  out  1  snoop address ready
acaddr  in  ACE_ACADDR_WIDTH  snoop address
acsnoop  in  ACE_ACSNOOP_WIDTH  snoop type
acprot  in  ACE_ACPROT_WIDTH  protection; ignored
crvalid  out  1  snoop response valid
crready  in  1  snoop response ready
crresp  out  ACE_CRRESP_WIDTH  {WasUnique,IsShared,PassDirty,Error,DataTransfer}
cdvalid  out  1  snoop data valid
cdready  in  1  snoop data ready
cddata  out  ACE_CDDATA_WIDTH  snoop data
cdlast  out  1  last data beat
lk_req  out  1  lookup request (level, held until lk_ack)
lk_addr  out  ACE_ACADDR_WIDTH  lookup address (registered acaddr)
lk_ack  in  1  lookup result valid, one-cycle pulse
lk_hit, lk_dirty, lk_unique  in  1 each  line state, sampled on lk_ack
rd_req  out  1  data beat read, one-cycle pulse
rd_beat  out  BEAT_IDX_W  beat index
rd_data  in  ACE_CDDATA_WIDTH  beat data, valid exactly one cycle after rd_req
upd_valid  out  1  state-update request
upd_ready  in  1  state-update accept
upd_inv, upd_clr_dirty, upd_clr_unique  out  1 each  update actions

Behaviour:
- Reset: acready=0, crvalid=0, cdvalid=0, cdlast=0, lk_req=0, rd_req=0, upd_valid=0; crresp/cddata/rd_beat=0; FSM=IDLE. A reset mid-snoop aborts it with no update.
- FSM: IDLE→LOOKUP→RESP→[DATA_RD⇄DATA_OUT]→[UPDATE]→IDLE.
- IDLE: acready=1. On acvalid&acready, register addr/snoop → LOOKUP. acready=0 in all other states.
- LOOKUP: lk_req=1 until lk_ack. On lk_ack, compute crresp plus the data/update flags → RESP.
- RESP: crvalid=1, crresp stable until crready. Then → DATA_RD if DataTransfer, else UPDATE if any update flag set, else IDLE.
- Response table, on hit (D=lk_dirty, U=lk_unique):
  - ReadOnce 0000: DT=1, IS=1, PD=0, WU=U; no update.
  - ReadShared 0001 / ReadClean 0010 / ReadNotSharedDirty 0011: DT=1, IS=1, PD=D, WU=U; clr_unique=1, clr_dirty=D.
  - ReadUnique 0111: DT=1, IS=0, PD=D, WU=U; inv=1.
  - CleanShared 1000: DT=D, IS=1, PD=D, WU=U; clr_dirty=D.
  - CleanInvalid 1001: DT=D, IS=0, PD=D, WU=U; inv=1.
  - MakeInvalid 1101: DT=0, PD=0, IS=0, WU=U; inv=1.
- Miss, or any other acsnoop (including DVM 1110/1111): crresp=0, no data, no update.
- Error bit is always 0.
- Beat order: start at b0 = acaddr[beat field], i.e. bits [$clog2(ACE_CDDATA_WIDTH/8) +: BEAT_IDX_W]. Increment modulo LINE_BEATS (wraps). Exactly LINE_BEATS beats.
- DATA_RD: rd_req=1 for one cycle with rd_beat → DATA_OUT.
- DATA_OUT: capture rd_data in the first cycle; cdvalid=1 from the following cycle, with cddata/cdlast stable until cdready. cdlast=1 on beat LINE_BEATS-1 of the sequence. After a non-last handshake → DATA_RD; after the last → UPDATE or IDLE, per the flags.
- Peak throughput is one beat per 3 cycles; accepted.
- UPDATE: upd_valid=1 with flags stable until upd_ready → IDLE. upd_inv takes precedence; clr flags are still driven as computed.
- CR always completes before the first CD beat. The state update always follows the last CD handshake, so data is never invalidated before it is sent.

Decomposition:
- Into offnariscv_pkg:
  - enum ace_acsnoop_e (the eight encodings above)
  - packed struct ace_crresp_t (5 fields)
  - localparam ACE_CACHE_LINE_BEATS = 4
- Sub-module ace_snoop_decode: combinational (acsnoop, hit, dirty, unique) → (crresp, need_data, upd flags). Makes the table directly unit-testable.

Test Plan:
- ReadShared, hit D=1 U=1, acaddr=0x1008 → crresp=5'b11101; CD beats 2,3,0,1 with cdlast on the 4th; then upd clr_unique=1, clr_dirty=1, inv=0.
- ReadUnique, hit D=0 U=1, acaddr=0x2000 → crresp=5'b10001; beats 0..3; upd_inv=1.
- CleanInvalid, hit D=0 → crresp=5'b10000; no cdvalid, upd_inv=1. Same with D=1 → 5'b10101 plus 4 beats.
- Any snoop that misses, and DVM 1111 → crresp=0; no CD, no upd_valid; acready=1 again 1 cycle after CR handshake.
- Backpressure: crready low 5 cycles, cdready toggling randomly, upd_ready low 3 cycles → all payloads stable while valid; acready stays 0 until the update completes.
- rst_n low during DATA_OUT beat 2 → next cycle all valids=0, acready=0; after release, acready=1 and no upd_valid for the aborted snoop.
